// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue:
// FSM encodings, default geometry and the count-width helper.
package prefetch_queue_pkg;

    localparam int PQ_DEPTH = 4;
    localparam int PQ_AW    = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic int pq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prefetch_queue_fifo.sv
// pq_fifo: synchronous circular byte buffer with push/pop/clear.
// Ports: clk, rst (async high), clear, push/push_data, pop, head_data, count.
module pq_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH,
    parameter int W     = 8,
    localparam int CW   = pq_cnt_w(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Storage is not reset; the head is only meaningful while count != 0.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches bytes over req/ack and hands them
// to the decoder via valid/ready with the head byte address in out_pc.
// Ports: clk, rst, flush/flush_addr, mem_req/mem_addr/mem_ack/mem_data,
//        out_valid/out_data/out_pc/out_ready, count.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH,
    parameter int AW    = PQ_AW,
    localparam int CW   = pq_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]    state;
    logic [AW-1:0] fetch_ptr;
    logic [7:0]    head_data;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;

    // A flush discards both the acked byte and any pop in that cycle.
    assign push       = (state == ST_FETCH) && mem_ack && !flush;
    assign pop        = out_valid && out_ready && !flush;
    assign count_next = count + CW'(push) - CW'(pop);

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head_data : 8'h00;

    pq_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            fetch_ptr <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            out_pc    <= '0;
        end else begin
            if (flush) begin
                fetch_ptr <= flush_addr;
                out_pc    <= flush_addr;
            end else if (pop) begin
                out_pc <= out_pc + AW'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    if (!flush && count < FULL) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_ptr;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        if (flush) begin
                            state   <= ST_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            fetch_ptr <= fetch_ptr + AW'(1);
                            if (count_next < FULL) begin
                                mem_addr <= fetch_ptr + AW'(1);
                            end else begin
                                state   <= ST_IDLE;
                                mem_req <= 1'b0;
                            end
                        end
                    end else if (flush) begin
                        // Request cannot be withdrawn; swallow its data.
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch queue feeding the decoder from program memory. It holds its own fetch pointer and issues byte reads over a req/ack memory handshake, buffering up to DEPTH bytes. It presents them in order to the decoder with a valid/ready handshake, together with the address of the head byte. It is the consumer side of the IP register path: the IP value loaded on a jump becomes `flush_addr` here, and `out_pc` is the architectural IP seen by the decoder.

## Interface
- `DEPTH`, default 4: queue capacity in bytes, power of two, 2..16.
- `AW`, default 8: address width; fetch pointer and `out_pc` wrap modulo 2^AW.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  discard queue contents; restart fetching at `flush_addr`.
- `flush_addr`  in  AW  new fetch address, sampled when `flush`=1.
- `mem_req`  out  1  read request; held until `mem_ack`.
- `mem_addr`  out  AW  read address; stable while `mem_req`=1.
- `mem_ack`  in  1  `mem_data` valid this cycle; ends the request.
- `mem_data`  in  8  returned byte.
- `out_valid`  out  1  head byte available.
- `out_data`  out  8  head byte.
- `out_pc`  out  AW  address of head byte (IP of the next byte consumed).
- `out_ready`  in  1  decoder consumes head when `out_valid`&`out_ready`.
- `count`  out  log2(DEPTH)+1  bytes currently held.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_pc`=0, `count`=0, fetch pointer 0, FSM in IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - FETCH: request outstanding; data is kept.
  - DRAIN: request outstanding; returned data is discarded.
- IDLE -> FETCH when `count` < DEPTH and `flush`=0. Drive `mem_req`=1 and `mem_addr` = fetch pointer.
- FETCH, `mem_ack`=1, `flush`=0:
  - Push `mem_data`; fetch pointer +1.
  - If count_next < DEPTH (count_next = count + 1 − pop), stay in FETCH with `mem_addr` = new pointer, `mem_req` held at 1.
  - Otherwise go to IDLE with `mem_req`=0.
- FETCH, `mem_ack`=0, `flush`=1: go to DRAIN. `mem_req` and `mem_addr` stay unchanged; the protocol forbids withdrawing a request.
- FETCH, `mem_ack`=1, `flush`=1: byte discarded; go to IDLE.
- DRAIN, `mem_ack`=1: byte discarded; go to IDLE.
- DRAIN, `flush`=1 again: reload the fetch pointer; stay in DRAIN.
- `flush` in any state:
  - Queue emptied (`count`=0, `out_valid`=0 next cycle).
  - Fetch pointer and `out_pc` set to `flush_addr`.
  - A same-cycle pop is ignored.
- Pop: head pointer +1, `out_pc` +1 (wraps), `count` −1.
- Push and pop in the same cycle: `count` unchanged.
- Overflow is impossible: a request is issued only when `count` < DEPTH, and only one request can be outstanding.
- The fetch pointer wraps from all-ones to 0 with no side effect.

## Timing
- `mem_req`/`mem_addr` are registered. The first request is asserted on the first clk edge after `rst` deasserts.
- Memory latency is arbitrary (≥0 wait cycles). With `mem_ack` tied high, throughput is 1 byte/cycle until full.
- A byte acked at edge N is visible on `out_valid`/`out_data` after edge N (registered storage, combinational read of head).
- `flush` at edge N: `out_valid`=0 and `out_pc`=`flush_addr` after edge N. The first request to `flush_addr` is issued at edge N+1 from IDLE, or one edge after the draining ack.
- `rst` mid-transfer clears everything immediately; an in-flight ack after reset is ignored.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, FETCH, DRAIN).
  - Default DEPTH and AW.
  - The count-width function.
- One natural sub-module: `pq_fifo`, a parameterised synchronous circular buffer with push/pop/clear, head/tail pointers and count.
- `prefetch_queue` keeps the FSM, fetch pointer and `out_pc`.

## Test plan
- Fill: reset, `mem_ack`=1 constant, `mem_data`=addr^8'hA5, `out_ready`=0 -> requests to 00,01,02,03 on consecutive cycles, then `mem_req`=0, `count`=4, `out_data`=A5, `out_pc`=00.
- Stream: continue with `out_ready`=1 -> `out_data` sequence A5,A4,A7,A6,A1…, `out_pc` +1 per cycle, `count` steady after refill, no gaps.
- Flush mid-request: `mem_ack`=0 for 3 cycles after a request to 05, pulse `flush` with `flush_addr`=8'h40 -> `mem_addr` stays 05 until ack, that byte is dropped, the next request is to 40, `out_valid`=0 until byte 40 arrives, then `out_pc`=40.
- Wrap: `flush_addr`=8'hFE -> fetch addresses FE,FF,00,01; `out_pc` goes FE->FF->00.
- Simultaneous ack, pop and flush with `count`=3 -> ack byte discarded, `count`=0, FSM in IDLE, next request to `flush_addr`.
- Async reset during an outstanding request (`mem_req`=1) -> `mem_req`, `out_valid` and `count` are 0 before the next clk edge; a following `mem_ack` pulse causes no push.
